// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_ctrl_pkg
// Brief   : State encoding and counter-width helper for the SPI master.
// Rev     : 1.0
// ============================================================================
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module  : spi_sclk_gen
// Brief   : Phase counter; ticks o_phase_end every DIV cycles while enabled.
// Rev     : 1.0
// ============================================================================
module spi_sclk_gen
  import spi_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_phase_first,
  output logic o_phase_end
);

  localparam int PW = cnt_width(DIV);
  localparam logic [PW-1:0] c_last = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;
  logic          w_end;

  assign w_end         = i_en && (r_cnt == c_last);
  assign o_phase_end   = w_end;
  assign o_phase_first = i_en && (r_cnt == '0);

  // Held at zero while disabled, so every enable rise starts a fresh phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_ctrl
// Brief   : SPI mode-0 master, one MSB-first full-duplex N-bit transfer/start.
// Rev     : 1.0
// ============================================================================
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int N   = 32,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] tx_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rx_data,
  output logic         sclk,
  output logic         cs_n,
  output logic         mosi,
  input  logic         miso
);

  localparam int BW = cnt_width(N);
  localparam logic [BW-1:0] c_last_bit = BW'(N - 1);

  spi_state_e    r_state;
  logic [N-1:0]  r_shift;
  logic [BW-1:0] r_bit_cnt;
  logic          r_miso_q;
  logic          r_sclk;
  logic          r_cs_n;
  logic          r_mosi;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_rx;

  logic w_en;
  logic w_first;
  logic w_end;
  logic w_sample;

  assign w_en = (r_state != ST_IDLE);

  spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_en),
    .o_phase_first (w_first),
    .o_phase_end   (w_end)
  );

  // With DIV=1 the sample and shift fall in the same cycle; bypass miso_q.
  assign w_sample = w_first ? miso : r_miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_miso_q  <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          if (start) begin
            r_shift   <= tx_data;
            r_mosi    <= tx_data[N-1];
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_end) begin
            r_sclk  <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_first) begin
            r_miso_q <= miso;
          end
          if (w_end) begin
            r_shift   <= {r_shift[N-2:0], w_sample};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_sclk    <= 1'b0;
            if (r_bit_cnt == c_last_bit) begin
              r_state <= ST_DONE;
            end else begin
              r_mosi  <= r_shift[N-2];
              r_state <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (w_end) begin
            r_sclk  <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_DONE: begin
          if (w_end) begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_rx    <= r_shift;
            r_mosi  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx;
  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_ctrl
// Brief   : Directed bench: 8-bit loopback instance and 32-bit slave instance.
// Rev     : 1.0
// ============================================================================
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, DIV=2 instance with miso looped back to mosi
  logic       rst_n8, start8, busy8, done8, sclk8, cs_n8, mosi8, miso8;
  logic [7:0] tx8, rx8;
  assign miso8 = mosi8;

  spi_master_ctrl #(.N(8), .DIV(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .tx_data(tx8),
    .busy(busy8), .done(done8), .rx_data(rx8),
    .sclk(sclk8), .cs_n(cs_n8), .mosi(mosi8), .miso(miso8)
  );

  // 32-bit, DIV=1 instance talking to a mode-0 slave model
  logic        rst_n32, start32, busy32, done32, sclk32, cs_n32, mosi32, miso32;
  logic [31:0] tx32, rx32;

  spi_master_ctrl #(.N(32), .DIV(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n32), .start(start32), .tx_data(tx32),
    .busy(busy32), .done(done32), .rx_data(rx32),
    .sclk(sclk32), .cs_n(cs_n32), .mosi(mosi32), .miso(miso32)
  );

  logic [31:0] slv_sh = 32'h0;
  logic [31:0] slv_rx = 32'h0;
  assign miso32 = slv_sh[31];
  always @(negedge cs_n32) slv_sh = 32'hDEADBEEF;
  always @(posedge sclk32) slv_rx = {slv_rx[30:0], mosi32};
  always @(negedge sclk32) slv_sh = {slv_sh[30:0], 1'b0};

  int         pulses8  = 0;
  logic [7:0] bits8    = 8'h0;
  int         done_cnt8 = 0;
  always @(posedge sclk8) begin
    pulses8 = pulses8 + 1;
    bits8   = {bits8[6:0], mosi8};
  end
  always @(negedge clk) if (done8 === 1'b1) done_cnt8 = done_cnt8 + 1;

  int vectors    = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an 8-bit transfer and return the cycle index at which done appears.
  task automatic run8(input logic [7:0] d, output int cyc);
    tx8    = d;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 100) begin
      tick();
      cyc = cyc + 1;
    end
  endtask

  int cyc;
  int n;
  int dc;

  initial begin
    rst_n8 = 1'b0; start8 = 1'b1; tx8 = 8'hFF;
    rst_n32 = 1'b0; start32 = 1'b0; tx32 = 32'h0;

    // Reset with start held high
    repeat (4) tick();
    chk("rst_cs_n", {31'd0, cs_n8}, 32'd1);
    chk("rst_sclk", {31'd0, sclk8}, 32'd0);
    chk("rst_mosi", {31'd0, mosi8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_rx",   {24'd0, rx8},   32'd0);
    chk("rst_no_sclk", pulses8, 32'd0);
    start8 = 1'b0;
    rst_n8 = 1'b1; rst_n32 = 1'b1;
    tick();

    // Loopback 0xA5
    pulses8 = 0; bits8 = 8'h0;
    tx8 = 8'hA5; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("c1_cs_n", {31'd0, cs_n8}, 32'd0);
    chk("c1_busy", {31'd0, busy8}, 32'd1);
    chk("c1_mosi", {31'd0, mosi8}, 32'd1);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 100) begin
      tick();
      cyc = cyc + 1;
    end
    chk("lb_done_cycle", cyc, 32'd35);
    chk("lb_rx", {24'd0, rx8}, 32'h000000A5);
    chk("lb_pulses", pulses8, 32'd8);
    chk("lb_mosi_bits", {24'd0, bits8}, 32'h000000A5);
    chk("lb_cs_n_done", {31'd0, cs_n8}, 32'd1);
    chk("lb_busy_done", {31'd0, busy8}, 32'd0);
    tick();
    chk("lb_done_width", {31'd0, done8}, 32'd0);

    // Slave model, N=32 DIV=1
    tx32 = 32'h12345678; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    cyc = 1;
    while (done32 !== 1'b1 && cyc < 200) begin
      tick();
      cyc = cyc + 1;
    end
    chk("slv_done_cycle", cyc, 32'd66);
    chk("slv_rx", rx32, 32'hDEADBEEF);
    chk("slv_captured", slv_rx, 32'h12345678);

    // Start while busy is ignored
    tick();
    pulses8 = 0; bits8 = 8'h0;
    dc = done_cnt8;
    tx8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (10) tick();
    tx8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (60) tick();
    chk("busy_done_count", done_cnt8 - dc, 32'd1);
    chk("busy_rx", {24'd0, rx8}, 32'h0000003C);
    chk("busy_mosi_bits", {24'd0, bits8}, 32'h0000003C);
    chk("busy_pulses", pulses8, 32'd8);

    // Back-to-back with start held high
    dc = done_cnt8;
    tx8 = 8'h5A; start8 = 1'b1;
    tick();
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 100) begin
      tick();
      cyc = cyc + 1;
    end
    chk("b2b_first_cycle", cyc, 32'd35);
    chk("b2b_gap_high", {31'd0, cs_n8}, 32'd1);
    tick();
    start8 = 1'b0;
    chk("b2b_gap_end", {31'd0, cs_n8}, 32'd0);
    chk("b2b_busy2", {31'd0, busy8}, 32'd1);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 100) begin
      tick();
      cyc = cyc + 1;
    end
    chk("b2b_second_cycle", cyc, 32'd35);
    tick();
    chk("b2b_done_count", done_cnt8 - dc, 32'd2);
    chk("b2b_rx", {24'd0, rx8}, 32'h0000005A);

    // Abort during the 4th SCLK high phase
    pulses8 = 0;
    dc = done_cnt8;
    tx8 = 8'hC3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!(pulses8 >= 4 && sclk8 === 1'b1) && n < 100) begin
      tick();
      n = n + 1;
    end
    chk("abort_reach_4th", {31'd0, (n < 100)}, 32'd1);
    rst_n8 = 1'b0;
    #1;
    chk("abort_cs_n", {31'd0, cs_n8}, 32'd1);
    chk("abort_sclk", {31'd0, sclk8}, 32'd0);
    chk("abort_rx", {24'd0, rx8}, 32'd0);
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    repeat (3) tick();
    rst_n8 = 1'b1;
    repeat (20) tick();
    chk("abort_no_done", done_cnt8 - dc, 32'd0);
    chk("abort_no_sclk", pulses8, 32'd4);
    pulses8 = 0; bits8 = 8'h0;
    run8(8'h3C, cyc);
    chk("post_abort_cycle", cyc, 32'd35);
    chk("post_abort_rx", {24'd0, rx8}, 32'h0000003C);
    chk("post_abort_bits", {24'd0, bits8}, 32'h0000003C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
